// File: rtl/seq_divider_pkg.sv
// Shared widths and controller state encoding for the sequential signed divider.
package seq_divider_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int ITER_N     = 16;
   localparam int CNT_W      = 5;
   localparam int REM_W      = DIVISOR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LDLO  = 3'd1,
      S_LDDV  = 3'd2,
      S_CALC  = 3'd3,
      S_DONEQ = 3'd4,
      S_DONER = 3'd5
   } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operator-facing bus: switch byte and go button in, display word and state code out.
interface seq_divider_if;
   import seq_divider_pkg::*;

   logic [DIVISOR_W-1:0]  sw;
   logic                  go;
   logic [DIVIDEND_W-1:0] display;
   logic [2:0]            state;

   modport master (output sw, go, input display, state);
   modport slave  (input sw, go, output display, state);

endinterface

// File: rtl/seq_divider_datapath.sv
// Operand registers plus 16-step restoring divider on magnitudes; one quotient bit per step.
// Sign correction is folded into the last step so results are final when it retires.
module div_datapath
   import seq_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIVISOR_W-1:0]  i_sw,
   input  logic                  i_ld_hi,
   input  logic                  i_ld_lo,
   input  logic                  i_ld_dv,
   input  logic                  i_setup,
   input  logic                  i_iter,
   input  logic                  i_last,
   output logic [DIVIDEND_W-1:0] o_dividend,
   output logic [DIVIDEND_W-1:0] o_quot,
   output logic [REM_W-1:0]      o_rem
);

   logic [DIVIDEND_W-1:0] r_dividend;
   logic [DIVISOR_W-1:0]  r_divisor;
   logic [DIVISOR_W-1:0]  r_dmag;
   logic [DIVIDEND_W-1:0] r_q;
   logic [REM_W-1:0]      r_prem;
   logic [DIVIDEND_W-1:0] r_quot;
   logic [REM_W-1:0]      r_rem;

   logic [DIVIDEND_W-1:0] w_dvd_mag;
   logic [DIVISOR_W-1:0]  w_dvs_mag;
   logic [REM_W-1:0]      w_shift;
   logic [REM_W-1:0]      w_sub;
   logic                  w_fit;
   logic [DIVIDEND_W-1:0] w_q_next;
   logic [REM_W-1:0]      w_p_next;
   logic [DIVIDEND_W-1:0] w_q_final;
   logic [REM_W-1:0]      w_r_final;
   logic                  w_div_zero;

   // |-32768| = 32768 still fits 16 unsigned bits, so -32768/-1 wraps to 0x8000 naturally
   assign w_dvd_mag = r_dividend[DIVIDEND_W-1] ? (~r_dividend + 16'd1) : r_dividend;
   assign w_dvs_mag = r_divisor[DIVISOR_W-1]   ? (~r_divisor + 8'd1)   : r_divisor;

   assign w_shift  = (r_prem << 1) | {{(REM_W-1){1'b0}}, r_q[DIVIDEND_W-1]};
   assign w_fit    = (w_shift >= {1'b0, r_dmag});
   assign w_sub    = w_shift - {1'b0, r_dmag};
   assign w_p_next = w_fit ? w_sub : w_shift;
   assign w_q_next = {r_q[DIVIDEND_W-2:0], w_fit};

   assign w_div_zero = (r_divisor == '0);
   assign w_q_final  = (r_dividend[DIVIDEND_W-1] ^ r_divisor[DIVISOR_W-1]) ?
                       (~w_q_next + 16'd1) : w_q_next;
   assign w_r_final  = r_dividend[DIVIDEND_W-1] ? (~w_p_next + 9'd1) : w_p_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dividend <= '0;
         r_divisor  <= '0;
         r_dmag     <= '0;
         r_q        <= '0;
         r_prem     <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
      end else begin
         if (i_ld_hi) r_dividend[DIVIDEND_W-1:DIVISOR_W] <= i_sw;
         if (i_ld_lo) r_dividend[DIVISOR_W-1:0]          <= i_sw;
         if (i_ld_dv) r_divisor                          <= i_sw;
         if (i_setup) begin
            r_q    <= w_dvd_mag;
            r_dmag <= w_dvs_mag;
            r_prem <= '0;
         end
         if (i_iter) begin
            r_q    <= w_q_next;
            r_prem <= w_p_next;
         end
         if (i_last) begin
            r_quot <= w_div_zero ? '1 : w_q_final;
            r_rem  <= w_div_zero ? '1 : w_r_final;
         end
      end
   end

   assign o_dividend = r_dividend;
   assign o_quot     = r_quot;
   assign o_rem      = r_rem;

endmodule

// File: rtl/seq_divider.sv
// Button-stepped controller for a signed 16/8 divider: load hi, load lo, load divisor, 17-cycle CALC, show Q then R.
// go acts on its rising edge only; edges while calculating are dropped.
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);

   state_t r_state, w_state_nxt;
   logic   r_go_q, r_go_armed;
   logic   [CNT_W-1:0] r_cnt;

   logic   w_go_edge;
   logic   w_ld_hi, w_ld_lo, w_ld_dv, w_setup, w_iter, w_last;
   logic   [DIVIDEND_W-1:0] w_dividend, w_quot, w_display;
   logic   [REM_W-1:0]      w_rem;

   // armed only once go has been seen low after reset, so a go held through reset never counts
   assign w_go_edge = bus.go & ~r_go_q & r_go_armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_go_q     <= 1'b0;
         r_go_armed <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_go_q     <= bus.go;
         r_go_armed <= r_go_armed | ~bus.go;
         r_cnt      <= (r_state == S_CALC) ? r_cnt + 5'd1 : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_hi     = 1'b0;
      w_ld_lo     = 1'b0;
      w_ld_dv     = 1'b0;
      w_setup     = 1'b0;
      w_iter      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE:  if (w_go_edge) begin w_state_nxt = S_LDLO; w_ld_hi = 1'b1; end
         S_LDLO:  if (w_go_edge) begin w_state_nxt = S_LDDV; w_ld_lo = 1'b1; end
         S_LDDV:  if (w_go_edge) begin w_state_nxt = S_CALC; w_ld_dv = 1'b1; end
         S_CALC: begin
            w_setup = (r_cnt == '0);
            w_iter  = (r_cnt != '0);
            if (r_cnt == CNT_W'(ITER_N)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONEQ;
            end
         end
         S_DONEQ: if (w_go_edge) w_state_nxt = S_DONER;
         S_DONER: if (w_go_edge) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   div_datapath u_dp (
      .clk        (clk),
      .rst        (rst),
      .i_sw       (bus.sw),
      .i_ld_hi    (w_ld_hi),
      .i_ld_lo    (w_ld_lo),
      .i_ld_dv    (w_ld_dv),
      .i_setup    (w_setup),
      .i_iter     (w_iter),
      .i_last     (w_last),
      .o_dividend (w_dividend),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   always_comb begin
      w_display = '0;
      case (r_state)
         S_LDLO:  w_display = {w_dividend[DIVIDEND_W-1:DIVISOR_W], 8'h00};
         S_LDDV:  w_display = w_dividend;
         S_DONEQ: w_display = w_quot;
         S_DONER: w_display = {{(DIVIDEND_W-REM_W){w_rem[REM_W-1]}}, w_rem};
         default: w_display = '0;
      endcase
   end

   assign bus.display = w_display;
   assign bus.state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against an integer-arithmetic reference of signed truncating division.
module tb_seq_divider;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_divider_if bus();

   seq_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      tick();
   endtask

   function automatic void ref_div(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                                   output logic [15:0] q, output logic [15:0] r);
      int a;
      int b;
      a = int'($signed({hi, lo}));
      b = int'($signed(dv));
      if (b == 0) begin
         q = 16'hFFFF;
         r = 16'hFFFF;
      end else begin
         q = 16'(a / b);
         r = 16'(a % b);
      end
   endfunction

   task automatic run_div(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                          input logic [15:0] eq, input logic [15:0] er,
                          input bit hold_first, input bit pulse_calc);
      int len;
      bus.sw = hi;
      if (hold_first) begin
         bus.go = 1'b1;
         repeat (50) tick();
         bus.go = 1'b0;
         tick();
      end else begin
         press();
      end
      check_val("st_ldlo", 16'(bus.state), 16'd1);
      check_val("disp_ldlo", bus.display, {hi, 8'h00});
      bus.sw = lo;
      press();
      check_val("st_lddv", 16'(bus.state), 16'd2);
      check_val("disp_lddv", bus.display, {hi, lo});
      bus.sw = dv;
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      len = 0;
      while (bus.state == 3'd3 && len < 100) begin
         len++;
         if (len == 1) check_val("disp_calc", bus.display, 16'h0000);
         bus.go = (pulse_calc && len < 16) ? len[0] : 1'b0;
         tick();
      end
      bus.go = 1'b0;
      check_val("calc_len", 16'(len), 16'd17);
      check_val("st_doneq", 16'(bus.state), 16'd4);
      check_val("quot", bus.display, eq);
      tick();
      press();
      check_val("st_doner", 16'(bus.state), 16'd5);
      check_val("rem", bus.display, er);
      press();
      check_val("st_idle", 16'(bus.state), 16'd0);
      check_val("disp_idle", bus.display, 16'h0000);
   endtask

   initial begin
      logic [7:0]  hi, lo, dv;
      logic [15:0] eq, er;

      rst    = 1'b1;
      bus.go = 1'b0;
      bus.sw = 8'h00;
      repeat (3) tick();
      check_val("rst_state", 16'(bus.state), 16'd0);
      check_val("rst_disp", bus.display, 16'h0000);
      rst = 1'b0;
      tick();

      run_div(8'h03, 8'hE8, 8'h07, 16'h008E, 16'h0006, 1'b0, 1'b0);
      run_div(8'hFC, 8'h18, 8'h07, 16'hFF72, 16'hFFFA, 1'b0, 1'b0);
      run_div(8'h03, 8'hE8, 8'hF9, 16'hFF72, 16'h0006, 1'b0, 1'b0);
      run_div(8'h80, 8'h00, 8'hFF, 16'h8000, 16'h0000, 1'b0, 1'b0);
      run_div(8'h12, 8'h34, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      run_div(8'h03, 8'hE8, 8'h07, 16'h008E, 16'h0006, 1'b1, 1'b1);

      // reset mid-CALC, then a fresh load must still divide correctly
      bus.sw = 8'h03; press();
      bus.sw = 8'hE8; press();
      bus.sw = 8'h07; bus.go = 1'b1; tick(); bus.go = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check_val("rst_calc_state", 16'(bus.state), 16'd0);
      check_val("rst_calc_disp", bus.display, 16'h0000);
      rst = 1'b0;
      repeat (20) tick();
      check_val("post_rst_state", 16'(bus.state), 16'd0);
      run_div(8'h03, 8'hE8, 8'h07, 16'h008E, 16'h0006, 1'b0, 1'b0);

      // go held high across reset release must not advance
      bus.go = 1'b1;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      check_val("held_go_state", 16'(bus.state), 16'd0);
      bus.go = 1'b0;
      tick();

      for (int i = 0; i < 30; i++) begin
         hi = 8'($urandom);
         lo = 8'($urandom);
         dv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         ref_div(hi, lo, dv, eq, er);
         run_div(hi, lo, dv, eq, er, 1'b0, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have no parameters; widths are fixed by package constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sw  input  8  operand byte entry (dividend high, dividend low, divisor).
REQ-005 go  input  1  advance button, level input; only its rising edge acts.
REQ-006 display  output  16  current value per state (REQ-014).
REQ-007 state  output  3  current controller state encoding.

Function
REQ-008 SHALL detect go rising edge internally with a registered copy of go; a held go SHALL advance exactly one step.
REQ-009 SHALL implement states IDLE=0, LDLO=1, LDDV=2, CALC=3, DONEQ=4, DONER=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-010 Transitions on go edge: IDLE->LDLO (latch sw as dividend[15:8]), LDLO->LDDV (latch sw as dividend[7:0]), LDDV->CALC (latch sw as divisor), DONEQ->DONER, DONER->IDLE.
REQ-011 Operands SHALL be two's-complement: dividend 16-bit signed, divisor 8-bit signed.
REQ-012 CALC SHALL last exactly 17 cycles: 1 setup cycle (take magnitudes, clear partial remainder), then 16 restoring-division iterations on magnitudes, one quotient bit per cycle, MSB first; partial remainder 9 bits.
REQ-013 On CALC exit: quotient negated if operand signs differ; remainder takes the dividend's sign (truncation toward zero); the sign fix SHALL occur in the final iteration cycle, so DONEQ holds final results on entry.
REQ-014 display: IDLE 16'h0000; LDLO {dividend[15:8],8'h00}; LDDV full dividend; CALC 16'h0000; DONEQ quotient; DONER remainder sign-extended to 16 bits.
REQ-015 go edges during CALC SHALL be ignored.
REQ-016 Divisor 0: SHALL still spend 17 cycles in CALC, then quotient=16'hFFFF and remainder display=16'hFFFF.
REQ-017 Dividend -32768 with divisor -1: quotient SHALL wrap to 16'h8000, remainder 0.
REQ-018 Latched operands SHALL be held until the next IDLE->LDLO load.

Reset
REQ-019 On rst: state=IDLE, display=16'h0000, operand, quotient, remainder and iteration-count registers cleared, go-edge register cleared.
REQ-020 rst SHALL take priority over go in every state, including mid-CALC; results SHALL not appear after a reset.
REQ-021 The first go edge after reset SHALL be counted only if go rises after rst deasserts; go held high through reset SHALL not advance.

Structure
REQ-022 A shared package SHALL hold the state encoding (3-bit typedef/constants), DIVIDEND_W=16, DIVISOR_W=8, ITER_N=16.
REQ-023 SHALL split into controller logic in seq_divider and one sub-module div_datapath (operand registers, magnitude and sign logic, shift/subtract iteration, result registers), driven by load and step strobes.
REQ-024 Iteration counter SHALL be 5 bits, counting 0..16 within CALC.

Verification
REQ-025 Load 0x03, 0xE8, 0x07 (1000/7) -> after 17 CALC cycles DONEQ display 0x008E; go -> DONER display 0x0006.
REQ-026 Load 0xFC, 0x18, 0x07 (-1000/7) -> quotient 0xFF72, remainder 0xFFFA; 1000/-7 -> quotient 0xFF72, remainder 0x0006.
REQ-027 Load 0x80, 0x00, 0xFF -> quotient 0x8000, remainder 0x0000; load 0x12, 0x34, 0x00 -> quotient 0xFFFF, remainder 0xFFFF, CALC still 17 cycles.
REQ-028 Hold go high for 50 cycles in IDLE -> state moves to 1 only; go pulses during CALC -> CALC length unchanged.
REQ-029 Assert rst at CALC cycle 8 -> next cycle state=0, display=0x0000; a fresh 1000/7 load then yields 0x008E.
